// File: rtl/seg7_scan_driver_if.sv
// Load/display bus of the multiplexed seven-segment driver.
// The master side loads values; the slave side (the driver) returns status and pin drives.
interface seg7_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BIN_WIDTH  = 14
);
    logic [BIN_WIDTH-1:0]  value_in;
    logic                  load;
    logic                  busy;
    logic                  overflow;
    logic [7:0]            seg;
    logic [NUM_DIGITS-1:0] an;

    modport master (output value_in, load, input busy, overflow, seg, an);
    modport slave  (input value_in, load, output busy, overflow, seg, an);
endinterface

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD (double-dabble, one bit per clock) feeding a time-multiplexed
// seven-segment display with leading-zero blanking, overflow pattern and pin polarity.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned BIN_WIDTH      = 14,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          LZ_BLANK       = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    parameter logic [7:0]  OVF_PATTERN    = 8'b00010000
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_driver_if.slave bus
);
    // Nibbles for any BIN_WIDTH-bit value, always at least one above the display.
    localparam int unsigned BinNib = (BIN_WIDTH * 302) / 1000 + 1;
    localparam int unsigned BcdNib = (BinNib > NUM_DIGITS) ? BinNib : NUM_DIGITS + 1;
    localparam int unsigned BcdW   = 4 * BcdNib;
    localparam int unsigned DispW  = 4 * NUM_DIGITS;
    localparam int unsigned CntW   = $clog2(BIN_WIDTH + 1);
    localparam int unsigned PresW  = $clog2(SCAN_DIV);
    localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e                  state_q, state_d;
    logic [BIN_WIDTH-1:0]    bin_q, bin_d;
    logic [BcdW-1:0]         bcd_q, bcd_d;
    logic [BcdW-1:0]         bcd_adj;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DispW-1:0]        disp_q, disp_d;
    logic                    ovf_q, ovf_d;
    logic [PresW-1:0]        pres_q, pres_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [3:0]              digit_nib;
    logic                    upper_nz;
    logic [7:0]              seg_raw;
    logic [NUM_DIGITS-1:0]   an_one;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;
        bcd_adj = bcd_q;
        for (int i = 0; i < BcdNib; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        case (state_q)
            StIdle: begin
                if (bus.load) begin
                    bin_d   = bus.value_in;
                    bcd_d   = '0;
                    cnt_d   = CntW'(BIN_WIDTH);
                    state_d = StShift;
                end
            end
            StShift: begin
                bcd_d = (bcd_adj << 1) | BcdW'(bin_q[BIN_WIDTH-1]);
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // Display only ever sees a finished conversion.
                disp_d  = bcd_q[DispW-1:0];
                ovf_d   = |bcd_q[BcdW-1:DispW];
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pres_d = pres_q + PresW'(1);
        idx_d  = idx_q;
        if (pres_q == PresW'(SCAN_DIV - 1)) begin
            pres_d = '0;
            idx_d  = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
        end

        digit_nib = disp_q[4*idx_q +: 4];
        upper_nz  = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx_q) && disp_q[4*j +: 4] != 4'd0) begin
                upper_nz = 1'b1;
            end
        end

        if (ovf_q) begin
            seg_raw = OVF_PATTERN;
        end else if (LZ_BLANK && idx_q != '0 && !upper_nz) begin
            seg_raw = 8'b00000000;
        end else begin
            case (digit_nib)
                4'd0:    seg_raw = 8'b11101011;
                4'd1:    seg_raw = 8'b00101000;
                4'd2:    seg_raw = 8'b10110011;
                4'd3:    seg_raw = 8'b10111010;
                4'd4:    seg_raw = 8'b01111000;
                4'd5:    seg_raw = 8'b11011010;
                4'd6:    seg_raw = 8'b11011011;
                4'd7:    seg_raw = 8'b10101000;
                4'd8:    seg_raw = 8'b11111011;
                4'd9:    seg_raw = 8'b11111010;
                default: seg_raw = 8'b00000000;
            endcase
        end
        seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;

        an_one        = '0;
        an_one[idx_q] = 1'b1;
        an_d          = an_one ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            pres_q  <= '0;
            idx_q   <= '0;
            seg_q   <= {8{SEG_ACTIVE_LOW}};
            an_q    <= {NUM_DIGITS{AN_ACTIVE_LOW}};
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            pres_q  <= pres_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.overflow = ovf_q;
    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
endmodule
